fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decode stage and directly downstream of `instruction_rom`. It holds the program counter and drives the ROM word address combinationally from it. The returned 32-bit instruction word, tagged with its PC, is pushed into a small in-order fetch queue, which is presented to decode through a valid/ready handshake. Redirects from the back end flush the queue, and a 0x00000000 word marks end of program.

---
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, ROM addressing and in-order fetch queue to decode
module fetch_unit #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_done
);

    localparam int         PW      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = QUEUE_DEPTH[PW:0];

    logic [31:0]   r_pc;
    logic [31:0]   r_q_pc    [QUEUE_DEPTH];
    logic [31:0]   r_q_instr [QUEUE_DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic          r_halted;

    logic          w_pop;
    logic          w_fetch;
    logic          w_push;
    logic          w_end_word;
    logic [1:0]    w_unused_bits;

    // Low bits of the redirect target are dropped; the PC is always word aligned.
    assign w_unused_bits = redirect_pc[1:0];

    assign rom_addr   = r_pc[9:2];
    assign out_valid  = (r_count != '0);
    assign fetch_done = r_halted;
    assign out_instr  = out_valid ? r_q_instr[r_head] : 32'h0;
    assign out_pc     = out_valid ? r_q_pc[r_head]    : 32'h0;

    assign w_pop      = out_valid && out_ready;
    // A slot is available if the queue has room or the head leaves this cycle.
    assign w_fetch    = !r_halted && !redirect_valid && ((r_count < DEPTH_C) || w_pop);
    assign w_end_word = (rom_data == 32'h0);
    assign w_push     = w_fetch && !w_end_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_pc     <= {redirect_pc[31:2], 2'b00};
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else begin
            if (w_push) begin
                r_q_pc[r_tail]    <= r_pc;
                r_q_instr[r_tail] <= rom_data;
                r_tail            <= r_tail + 1'b1;
                r_pc              <= r_pc + 32'd4;
            end
            if (w_fetch && w_end_word) begin
                r_halted <= 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a queue-based model
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_done;

    logic [31:0] rom [256];

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    fetch_unit #(.QUEUE_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_done(fetch_done)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_halted;
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare visible outputs to the model, advance the model by the spec rules, then clock.
    task automatic step();
        logic        v;
        logic        pop;
        int          sz;
        logic [31:0] w;
        #1;
        v = (mq.size() != 0);
        check("out_valid",  {31'h0, out_valid},  {31'h0, v});
        check("out_pc",     out_pc,    v ? mq[0].pc  : 32'h0);
        check("out_instr",  out_instr, v ? mq[0].ins : 32'h0);
        check("rom_addr",   {24'h0, rom_addr},   {24'h0, m_pc[9:2]});
        check("fetch_done", {31'h0, fetch_done}, {31'h0, m_halted});
        sz  = mq.size();
        pop = v && out_ready;
        if (rst) begin
            mq.delete();
            m_pc     = RPC;
            m_halted = 1'b0;
        end else if (redirect_valid) begin
            mq.delete();
            m_pc     = redirect_pc & 32'hFFFF_FFFC;
            m_halted = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (!m_halted && (sz < DEPTH || pop)) begin
                w = rom[(m_pc >> 2) % 256];
                if (w != 32'h0) begin
                    mq.push_back('{pc: m_pc, ins: w});
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_halted = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic rdy);
        out_ready = rdy;
        redirect_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect(input logic [31:0] pc, input logic rdy);
        out_ready = rdy;
        redirect_valid = 1'b1;
        redirect_pc = pc;
        rst = 1'b0;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        for (int i = 0; i < 6; i++) rom[i] = 32'h11 * (i + 1);
        rom[64]  = 32'hCAFE_0040;
        rom[255] = 32'hFFFF_00FF;
        rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        mq.delete(); m_pc = RPC; m_halted = 1'b0;

        // Reset state, then stream words 0..5 and halt on word 6.
        rst = 1'b1;
        step();
        run(12, 1'b1);
        check("halt_after_stream", {31'h0, fetch_done}, 32'h1);
        check("empty_after_stream", {31'h0, out_valid}, 32'h0);

        // Backpressure until full, then release.
        redirect(32'h0, 1'b0);
        run(10, 1'b0);
        check("full_rom_addr", {24'h0, rom_addr}, 32'h4);
        check("full_head_pc", out_pc, 32'h0);
        check("full_head_instr", out_instr, 32'h11);
        run(10, 1'b1);

        // Redirect with three entries queued.
        redirect(32'h0, 1'b0);
        run(3, 1'b0);
        redirect(32'h0000_0103, 1'b0);
        check("redir_valid_low", {31'h0, out_valid}, 32'h0);
        run(1, 1'b1);
        check("redir_first_pc", out_pc, 32'h100);
        check("redir_first_instr", out_instr, 32'hCAFE_0040);
        run(4, 1'b1);

        // Redirect after halt.
        redirect(32'h8, 1'b1);
        check("done_cleared", {31'h0, fetch_done}, 32'h0);
        run(8, 1'b1);

        // Address wrap past word 255.
        redirect(32'h3FC, 1'b1);
        check("wrap_addr_255", {24'h0, rom_addr}, 32'hFF);
        run(1, 1'b1);
        check("wrap_addr_0", {24'h0, rom_addr}, 32'h0);
        check("wrap_pc_3fc", out_pc, 32'h3FC);
        run(1, 1'b1);
        check("wrap_pc_400", out_pc, 32'h400);
        run(8, 1'b1);

        // Reset while full.
        redirect(32'h0, 1'b0);
        run(6, 1'b0);
        rst = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_done", {31'h0, fetch_done}, 32'h0);
        check("rst_rom_addr", {24'h0, rom_addr}, {24'h0, RPC[9:2]});
        run(3, 1'b1);

        // Randomized traffic over a random program.
        for (int i = 0; i < 256; i++)
            rom[i] = ($urandom_range(0, 19) == 0) ? 32'h0 : ($urandom() | 32'h1);
        for (int c = 0; c < 1500; c++) begin
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom();
            rst            = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
